// File: rtl/multi_warp_scalar_reg_file_pkg.sv
// Shared types for the multi-warp scalar register file: data word, write-source
// select and the warp/register index types.
package multi_warp_scalar_reg_file_pkg;

   localparam int DATA_WIDTH        = 32;
   localparam int DEFAULT_NUM_WARPS = 4;
   localparam int DEFAULT_NUM_REGS  = 32;

   typedef logic [DATA_WIDTH-1:0]                 data_t;
   typedef logic [$clog2(DEFAULT_NUM_WARPS)-1:0]  warp_id_t;
   typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0]   reg_idx_t;

   // Encodings 5..7 are unused and flagged as illegal on write-back.
   typedef enum logic [2:0] {
      ALU_OUT          = 3'd0,
      LSU_OUT          = 3'd1,
      IMMEDIATE        = 3'd2,
      PC_PLUS_1        = 3'd3,
      VECTOR_TO_SCALAR = 3'd4
   } reg_input_mux_t;

endpackage

// File: rtl/multi_warp_scalar_reg_file_scoreboard.sv
// Per-warp pending-write scoreboard: one busy bit per register, set on
// reservation, cleared on write-back, with two combinational query ports.
module scalar_scoreboard #(
   parameter int NUM_WARPS = 4,
   parameter int NUM_REGS  = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         set_valid,
   input  logic [$clog2(NUM_WARPS)-1:0] set_warp,
   input  logic [$clog2(NUM_REGS)-1:0]  set_addr,
   input  logic                         clr_valid,
   input  logic [$clog2(NUM_WARPS)-1:0] clr_warp,
   input  logic [$clog2(NUM_REGS)-1:0]  clr_addr,
   input  logic [$clog2(NUM_WARPS)-1:0] q1_warp,
   input  logic [$clog2(NUM_REGS)-1:0]  q1_addr,
   output logic                         q1_busy,
   input  logic [$clog2(NUM_WARPS)-1:0] q2_warp,
   input  logic [$clog2(NUM_REGS)-1:0]  q2_addr,
   output logic                         q2_busy
);

   localparam int WARP_W = $clog2(NUM_WARPS);

   logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_flat;

   generate
      for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
         logic [NUM_REGS-1:0] busy_reg;
         logic                set_hit;
         logic                clr_hit;

         assign set_hit = set_valid && (set_warp == WARP_W'(gi)) && (set_addr != '0);
         assign clr_hit = clr_valid && (clr_warp == WARP_W'(gi));

         // The set is applied last so a reservation beats a same-cycle write-back.
         always_ff @(posedge clk) begin
            if (reset) begin
               busy_reg <= '0;
            end else begin
               if (clr_hit) busy_reg[clr_addr] <= 1'b0;
               if (set_hit) busy_reg[set_addr] <= 1'b1;
            end
         end

         assign busy_flat[gi] = busy_reg;
      end
   endgenerate

   assign q1_busy = busy_flat[q1_warp][q1_addr];
   assign q2_busy = busy_flat[q2_warp][q2_addr];

endmodule

// File: rtl/multi_warp_scalar_reg_file.sv
// Banked scalar register file, one bank per warp, with registered two-port
// read, write-back forwarding, a pending-write scoreboard and per-warp exec mask.
module multi_warp_scalar_reg_file #(
   parameter int DATA_WIDTH = multi_warp_scalar_reg_file_pkg::DATA_WIDTH,
   parameter int NUM_WARPS  = 4,
   parameter int NUM_REGS   = 32,
   parameter int PC_WIDTH   = 8
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          rd_req_valid,
   input  logic [$clog2(NUM_WARPS)-1:0]                  rd_warp,
   input  logic [$clog2(NUM_REGS)-1:0]                   rs1_addr,
   input  logic [$clog2(NUM_REGS)-1:0]                   rs2_addr,
   output logic                                          rd_rsp_valid,
   output logic [DATA_WIDTH-1:0]                         rs1_data,
   output logic [DATA_WIDTH-1:0]                         rs2_data,
   output logic                                          rs1_busy,
   output logic                                          rs2_busy,
   input  logic                                          reserve_valid,
   input  logic [$clog2(NUM_WARPS)-1:0]                  reserve_warp,
   input  logic [$clog2(NUM_REGS)-1:0]                   reserve_addr,
   input  logic                                          wb_valid,
   input  logic [$clog2(NUM_WARPS)-1:0]                  wb_warp,
   input  logic [$clog2(NUM_REGS)-1:0]                   wb_addr,
   input  multi_warp_scalar_reg_file_pkg::reg_input_mux_t wb_mux,
   input  logic [DATA_WIDTH-1:0]                         alu_out,
   input  logic [DATA_WIDTH-1:0]                         lsu_out,
   input  logic [DATA_WIDTH-1:0]                         immediate,
   input  logic [DATA_WIDTH-1:0]                         vector_to_scalar_data,
   input  logic [PC_WIDTH-1:0]                           pc,
   output logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]          exec_mask,
   output logic                                          wb_error
);

   import multi_warp_scalar_reg_file_pkg::*;

   localparam int WARP_W = $clog2(NUM_WARPS);

   logic [DATA_WIDTH-1:0] wb_data;
   logic                  wb_legal;
   logic                  wr_en;
   logic [PC_WIDTH:0]     pc_plus_1;

   assign pc_plus_1 = {1'b0, pc} + {{PC_WIDTH{1'b0}}, 1'b1};

   always_comb begin
      wb_data  = '0;
      wb_legal = 1'b1;
      case (wb_mux)
         ALU_OUT:          wb_data = alu_out;
         LSU_OUT:          wb_data = lsu_out;
         IMMEDIATE:        wb_data = immediate;
         PC_PLUS_1:        wb_data = DATA_WIDTH'(pc_plus_1);
         VECTOR_TO_SCALAR: wb_data = vector_to_scalar_data;
         default:          wb_legal = 1'b0;
      endcase
   end

   assign wr_en = wb_valid && wb_legal && (wb_addr != '0);

   logic [NUM_WARPS-1:0][DATA_WIDTH-1:0] rs1_word;
   logic [NUM_WARPS-1:0][DATA_WIDTH-1:0] rs2_word;

   // The top register of each bank is the execution mask and resets to all ones.
   generate
      for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
         logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int r = 0; r < NUM_REGS; r++) begin
                  regs_reg[r] <= (r == NUM_REGS - 1) ? '1 : '0;
               end
            end else if (wr_en && (wb_warp == WARP_W'(gi))) begin
               regs_reg[wb_addr] <= wb_data;
            end
         end

         assign rs1_word[gi]  = regs_reg[rs1_addr];
         assign rs2_word[gi]  = regs_reg[rs2_addr];
         assign exec_mask[gi] = regs_reg[NUM_REGS-1];
      end
   endgenerate

   logic fwd1;
   logic fwd2;
   assign fwd1 = wr_en && (wb_warp == rd_warp) && (wb_addr == rs1_addr);
   assign fwd2 = wr_en && (wb_warp == rd_warp) && (wb_addr == rs2_addr);

   logic                  rd_rsp_valid_reg;
   logic [DATA_WIDTH-1:0] rs1_data_reg;
   logic [DATA_WIDTH-1:0] rs2_data_reg;
   logic                  wb_error_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_rsp_valid_reg <= 1'b0;
         rs1_data_reg     <= '0;
         rs2_data_reg     <= '0;
         wb_error_reg     <= 1'b0;
      end else begin
         rd_rsp_valid_reg <= rd_req_valid;
         wb_error_reg     <= wb_valid && !wb_legal;
         if (rd_req_valid) begin
            rs1_data_reg <= (rs1_addr == '0) ? '0 : (fwd1 ? wb_data : rs1_word[rd_warp]);
            rs2_data_reg <= (rs2_addr == '0) ? '0 : (fwd2 ? wb_data : rs2_word[rd_warp]);
         end
      end
   end

   assign rd_rsp_valid = rd_rsp_valid_reg;
   assign rs1_data     = rs1_data_reg;
   assign rs2_data     = rs2_data_reg;
   assign wb_error     = wb_error_reg;

   scalar_scoreboard #(
      .NUM_WARPS (NUM_WARPS),
      .NUM_REGS  (NUM_REGS)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .set_valid (reserve_valid),
      .set_warp  (reserve_warp),
      .set_addr  (reserve_addr),
      .clr_valid (wb_valid),
      .clr_warp  (wb_warp),
      .clr_addr  (wb_addr),
      .q1_warp   (rd_warp),
      .q1_addr   (rs1_addr),
      .q1_busy   (rs1_busy),
      .q2_warp   (rd_warp),
      .q2_addr   (rs2_addr),
      .q2_busy   (rs2_busy)
   );

endmodule

// File: tb/tb_multi_warp_scalar_reg_file.sv
// Directed and randomized bench for multi_warp_scalar_reg_file against an
// array-based model of register contents and pending bits.
module tb_multi_warp_scalar_reg_file;
   import multi_warp_scalar_reg_file_pkg::*;

   localparam int DW = 32;
   localparam int NW = 4;
   localparam int NR = 32;
   localparam int PW = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 rd_req_valid;
   logic [1:0]           rd_warp;
   logic [4:0]           rs1_addr, rs2_addr;
   logic                 rd_rsp_valid;
   logic [DW-1:0]        rs1_data, rs2_data;
   logic                 rs1_busy, rs2_busy;
   logic                 reserve_valid;
   logic [1:0]           reserve_warp;
   logic [4:0]           reserve_addr;
   logic                 wb_valid;
   logic [1:0]           wb_warp;
   logic [4:0]           wb_addr;
   reg_input_mux_t       wb_mux;
   logic [DW-1:0]        alu_out, lsu_out, immediate, vector_to_scalar_data;
   logic [PW-1:0]        pc;
   logic [NW-1:0][DW-1:0] exec_mask;
   logic                 wb_error;

   multi_warp_scalar_reg_file #(
      .DATA_WIDTH (DW), .NUM_WARPS (NW), .NUM_REGS (NR), .PC_WIDTH (PW)
   ) dut (
      .clk (clk), .reset (reset),
      .rd_req_valid (rd_req_valid), .rd_warp (rd_warp),
      .rs1_addr (rs1_addr), .rs2_addr (rs2_addr),
      .rd_rsp_valid (rd_rsp_valid), .rs1_data (rs1_data), .rs2_data (rs2_data),
      .rs1_busy (rs1_busy), .rs2_busy (rs2_busy),
      .reserve_valid (reserve_valid), .reserve_warp (reserve_warp), .reserve_addr (reserve_addr),
      .wb_valid (wb_valid), .wb_warp (wb_warp), .wb_addr (wb_addr), .wb_mux (wb_mux),
      .alu_out (alu_out), .lsu_out (lsu_out), .immediate (immediate),
      .vector_to_scalar_data (vector_to_scalar_data), .pc (pc),
      .exec_mask (exec_mask), .wb_error (wb_error)
   );

   always #5 clk = ~clk;

   // Reference state: register contents, pending bits, expected registered outputs.
   logic [DW-1:0] m_regs [NW][NR];
   bit            m_busy [NW][NR];
   logic [DW-1:0] exp_rs1, exp_rs2;
   logic          exp_valid, exp_err;
   int            errors = 0;
   int            checks = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int w = 0; w < NW; w++)
         for (int r = 0; r < NR; r++) begin
            m_regs[w][r] = (r == NR - 1) ? '1 : '0;
            m_busy[w][r] = 1'b0;
         end
      exp_valid = 1'b0; exp_rs1 = '0; exp_rs2 = '0; exp_err = 1'b0;
   endtask

   function automatic logic [DW-1:0] source_value();
      case (wb_mux)
         ALU_OUT:          return alu_out;
         LSU_OUT:          return lsu_out;
         IMMEDIATE:        return immediate;
         PC_PLUS_1:        return DW'(pc) + 32'd1;
         VECTOR_TO_SCALAR: return vector_to_scalar_data;
         default:          return '0;
      endcase
   endfunction

   task automatic idle();
      reset = 1'b0; rd_req_valid = 1'b0; reserve_valid = 1'b0; wb_valid = 1'b0;
      wb_mux = ALU_OUT;
   endtask

   // One clock: check busy before the edge, advance the model, check after the edge.
   task automatic cycle();
      logic          legal;
      logic [127:0]  em;
      #1;
      check("rs1_busy", rs1_busy, m_busy[rd_warp][rs1_addr]);
      check("rs2_busy", rs2_busy, m_busy[rd_warp][rs2_addr]);
      if (reset) begin
         model_reset();
      end else begin
         legal = (int'(wb_mux) <= 4);
         if (wb_valid && legal && wb_addr != 0) m_regs[wb_warp][wb_addr] = source_value();
         if (wb_valid) m_busy[wb_warp][wb_addr] = 1'b0;
         if (reserve_valid && reserve_addr != 0) m_busy[reserve_warp][reserve_addr] = 1'b1;
         exp_err   = wb_valid && !legal;
         exp_valid = rd_req_valid;
         if (rd_req_valid) begin
            exp_rs1 = m_regs[rd_warp][rs1_addr];
            exp_rs2 = m_regs[rd_warp][rs2_addr];
         end
      end
      @(posedge clk); #1;
      for (int w = 0; w < NW; w++) em[w*32 +: 32] = m_regs[w][NR-1];
      check("rd_rsp_valid", rd_rsp_valid, exp_valid);
      check("rs1_data", rs1_data, exp_rs1);
      check("rs2_data", rs2_data, exp_rs2);
      check("wb_error", wb_error, exp_err);
      check("exec_mask", exec_mask, em);
   endtask

   function automatic logic [4:0] pick_addr();
      int k;
      k = $urandom_range(0, 3);
      if (k == 0) return 5'd0;
      if (k == 1) return 5'd31;
      return 5'($urandom_range(1, 8));
   endfunction

   task automatic rand_inputs();
      logic [2:0] sel;
      rd_req_valid  = 1'($urandom_range(0, 1));
      rd_warp       = 2'($urandom_range(0, 3));
      rs1_addr      = pick_addr();
      rs2_addr      = pick_addr();
      reserve_valid = ($urandom_range(0, 2) == 0);
      reserve_warp  = 2'($urandom_range(0, 3));
      reserve_addr  = pick_addr();
      wb_valid      = 1'($urandom_range(0, 1));
      wb_warp       = 2'($urandom_range(0, 3));
      wb_addr       = pick_addr();
      sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      wb_mux = reg_input_mux_t'(sel);
      alu_out = $urandom; lsu_out = $urandom; immediate = $urandom;
      vector_to_scalar_data = $urandom; pc = 8'($urandom);
   endtask

   task automatic wb(input logic [1:0] w, input logic [4:0] a, input reg_input_mux_t m, input logic [DW-1:0] v);
      wb_valid = 1'b1; wb_warp = w; wb_addr = a; wb_mux = m;
      alu_out = v; lsu_out = v; immediate = v; vector_to_scalar_data = v;
   endtask

   task automatic rd(input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a2);
      rd_req_valid = 1'b1; rd_warp = w; rs1_addr = a1; rs2_addr = a2;
   endtask

   initial begin
      rd_warp = '0; rs1_addr = '0; rs2_addr = '0; reserve_warp = '0; reserve_addr = '0;
      wb_warp = '0; wb_addr = '0; alu_out = '0; lsu_out = '0; immediate = '0;
      vector_to_scalar_data = '0; pc = '0;
      idle(); reset = 1'b1;
      cycle();
      check("reset_mask", exec_mask, {128{1'b1}});

      // Exec-mask register reads as all ones, r5 as zero after reset.
      idle(); rd(2, 31, 5); cycle();
      check("read_r31_w2", rs1_data, 32'hFFFF_FFFF);
      check("read_r5_w2", rs2_data, 32'h0);

      // Same-cycle forwarding, and warp isolation.
      idle(); wb(1, 7, IMMEDIATE, 32'h1234); rd(1, 7, 0); cycle();
      check("fwd_w1_r7", rs1_data, 32'h1234);
      idle(); rd(0, 7, 7); cycle();
      check("iso_w0_r7", rs1_data, 32'h0);

      // pc+1 carries past PC_WIDTH; writes to r0 are dropped.
      idle(); wb(0, 3, PC_PLUS_1, 32'h0); pc = 8'hFF; cycle();
      idle(); rd(0, 3, 0); cycle();
      check("pc_plus_1", rs1_data, 32'h100);
      idle(); wb(0, 0, ALU_OUT, 32'hDEAD); rd(0, 0, 0); cycle();
      check("r0_fwd_zero", rs1_data, 32'h0);
      idle(); rd(0, 0, 3); cycle();
      check("r0_zero", rs1_data, 32'h0);

      // Scoreboard set, set-beats-clear, then clear.
      idle(); reserve_valid = 1'b1; reserve_warp = 3; reserve_addr = 9; cycle();
      idle(); rd_warp = 3; rs1_addr = 9; #1;
      check("busy_set", rs1_busy, 1'b1);
      reserve_valid = 1'b1; reserve_warp = 3; reserve_addr = 9; wb(3, 9, ALU_OUT, 32'h77); cycle();
      idle(); rd_warp = 3; rs1_addr = 9; #1;
      check("busy_set_wins", rs1_busy, 1'b1);
      wb(3, 9, ALU_OUT, 32'h78); cycle();
      idle(); rd_warp = 3; rs1_addr = 9; #1;
      check("busy_cleared", rs1_busy, 1'b0);

      // Exec mask follows r31 of its own warp only.
      idle(); wb(1, 31, ALU_OUT, 32'h0000_000F); cycle();
      check("mask_w1", exec_mask[1], 32'hF);
      check("mask_others", {exec_mask[3], exec_mask[2], exec_mask[0]}, {96{1'b1}});

      // Illegal write source: one-cycle error pulse, no write.
      idle(); wb(0, 4, ALU_OUT, 32'h55); cycle();
      idle(); wb(0, 4, reg_input_mux_t'(3'd6), 32'hBAD); cycle();
      check("wb_error_pulse", wb_error, 1'b1);
      idle(); rd(0, 4, 0); cycle();
      check("wb_error_drop", wb_error, 1'b0);
      check("r4_unchanged", rs1_data, 32'h55);

      // Random traffic, reset mid-stream with live requests, more random traffic.
      for (int i = 0; i < 150; i++) begin
         rand_inputs(); reset = 1'b0; cycle();
      end
      rand_inputs(); reset = 1'b1; cycle();
      reset = 1'b0;
      check("rst_rsp_valid", rd_rsp_valid, 1'b0);
      check("rst_data", {rs1_data, rs2_data}, 64'h0);
      check("rst_wb_error", wb_error, 1'b0);
      check("rst_mask", exec_mask, {128{1'b1}});
      idle();
      for (int w = 0; w < NW; w++) begin
         rd_warp = 2'(w); rs1_addr = 5'(w + 5); rs2_addr = 5'(w + 1); #1;
         check("rst_busy", {rs1_busy, rs2_busy}, 2'b00);
      end
      for (int i = 0; i < 150; i++) begin
         rand_inputs(); reset = 1'b0; cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_warp_scalar_reg_file.md
MULTI_WARP_SCALAR_REG_FILE -- requirements
Module: multi_warp_scalar_reg_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), scalar register width.
REQ-002 SHALL have parameter NUM_WARPS, default 4, number of independent register banks (one per warp).
REQ-003 SHALL have parameter NUM_REGS, default 32, registers per warp; index 0 is hard zero and index NUM_REGS-1 is the execution mask.
REQ-004 SHALL have parameter PC_WIDTH, default 8, width of pc.
REQ-005 SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- rd_req_valid  in  1  read request.
- rd_warp  in  $clog2(NUM_WARPS)  warp being read.
- rs1_addr, rs2_addr  in  $clog2(NUM_REGS)  source indices.
- rd_rsp_valid  out  1  read data valid.
- rs1_data, rs2_data  out  DATA_WIDTH  registered read data.
- rs1_busy, rs2_busy  out  1  combinational scoreboard hit for the current rd_warp/rs*_addr.
- reserve_valid  in  1  mark a destination pending.
- reserve_warp  in  warp width  warp of the reservation.
- reserve_addr  in  reg width  register index of the reservation.
- wb_valid  in  1  write-back strobe.
- wb_warp  in  warp width  warp of the write-back.
- wb_addr  in  reg width  register index of the write-back.
- wb_mux  in  reg_input_mux_t  write source.
- alu_out, lsu_out, immediate, vector_to_scalar_data  in  DATA_WIDTH  write sources.
- pc  in  PC_WIDTH  pc of the write-back instruction.
- exec_mask  out  NUM_WARPS x DATA_WIDTH  per-warp mask register contents.
- wb_error  out  1  illegal wb_mux pulse.

Function
REQ-006 SHALL return data one cycle after rd_req_valid: request at edge N gives rd_rsp_valid=1 and data valid after edge N+1; with no request, rd_rsp_valid=0 and data holds.
REQ-007 SHALL return 0 for any read of index 0, regardless of writes.
REQ-008 SHALL forward: if wb_valid with matching wb_warp/wb_addr (addr!=0) coincides with a read request, the returned data SHALL be the new write value.
REQ-009 SHALL write on wb_valid when wb_addr!=0: ALU_OUT->alu_out, LSU_OUT->lsu_out, IMMEDIATE->immediate, PC_PLUS_1->zero-extended pc+1 truncated to DATA_WIDTH, VECTOR_TO_SCALAR->vector_to_scalar_data.
REQ-010 SHALL ignore writes to index 0 and SHALL clear the scoreboard bit with no write.
REQ-011 SHALL not write when wb_mux is illegal, and SHALL pulse wb_error high for one cycle.
REQ-012 SHALL keep busy[w][r]: set by reserve_valid (r!=0), cleared by wb_valid for the same w/r; on simultaneous set and clear of the same entry, set SHALL win.
REQ-013 SHALL drive rs*_busy from busy state before the current edge's updates, with no same-cycle bypass.
REQ-014 SHALL drive exec_mask[w] combinationally from register NUM_REGS-1 of warp w.
REQ-015 SHALL keep warps fully isolated: no operation on warp w changes another warp's registers or busy bits.

Reset
REQ-016 SHALL, on reset, set all registers of all warps to 0 except index NUM_REGS-1, which SHALL become all ones.
REQ-017 SHALL, on reset, clear all busy bits and drive rd_rsp_valid=0, rs1_data=rs2_data=0, wb_error=0.
REQ-018 SHALL let reset take priority over simultaneous read, reserve and wb, dropping all in-flight requests.

Structure
REQ-019 SHALL take data_t, reg_input_mux_t and DATA_WIDTH from the shared package; the warp_id_t and reg_idx_t typedefs SHALL be added there.
REQ-020 SHALL place the busy-bit array in sub-module scalar_scoreboard (set/clear/two query ports).

Verification
REQ-021 Reset, then read warp 2 r31 and r5 -> after 1 cycle: rd_rsp_valid=1, rs1_data=0xFFFFFFFF, rs2_data=0.
REQ-022 wb warp1 r7 IMMEDIATE 0x1234 alongside read warp1 r7 -> rs1_data=0x1234 next cycle; warp0 r7 still reads 0.
REQ-023 wb warp0 r3 PC_PLUS_1 with pc=0xFF, PC_WIDTH=8 -> r3=0x100; wb r0 ALU_OUT 0xDEAD -> r0 reads 0.
REQ-024 reserve warp3 r9, then query warp3 r9 -> rs1_busy=1; reserve+wb same cycle -> busy stays 1; wb alone -> busy 0 next cycle.
REQ-025 Write warp1 r31=0x0000000F -> exec_mask[1]=0xF same cycle after edge, other masks all ones; assert reset mid-stream -> all state as REQ-016/017.
REQ-026 Drive wb_mux illegal on warp0 r4 -> wb_error pulses one cycle, r4 unchanged.
